// File: rtl/spram_ctrl_if.sv
// spram_ctrl_if: request/response channels between a requester and spram_ctrl.
//
// Request channel (valid/ready, accepted on req_valid & req_ready):
//   req_valid  requester -> ctrl   request present
//   req_ready  ctrl -> requester   controller accepts this cycle
//   req_we     requester -> ctrl   1 = write, 0 = read
//   req_addr   requester -> ctrl   word address (AW bits)
//   req_wdata  requester -> ctrl   write data (DW bits)
//   req_be     requester -> ctrl   byte enables, bit i covers bits 8i+7:8i
// Response channel (valid/ready, read data only):
//   rsp_valid  ctrl -> requester   read response present
//   rsp_ready  requester -> ctrl   requester takes response
//   rsp_rdata  ctrl -> requester   read data, stable while rsp_valid

interface spram_ctrl_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic [DW/8-1:0] req_be;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/spram_ctrl.sv
// spram_ctrl: request sequencer in front of a single-port RAM (one access per cycle,
// read data valid in the cycle after the read is issued).
//
// Turns a valid/ready request stream into registered RAM cycles and returns read data on
// a held valid/ready response channel. Writes produce no response. Only one read is in
// flight at a time.
//
// Optional feature: define SPRAM_CTRL_BYTE_EN to honour req_be on writes. All-ones
// enables write directly, zero enables are accepted with no RAM access, and partial
// enables run a read-modify-write (RAM read, merge, RAM write). Without the macro req_be
// is ignored and every write is full-word.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   bus        spram_ctrl_if slave modport (request and response channels)
//   ram_me     RAM enable (registered)
//   ram_wen    RAM write enable (registered)
//   ram_addr   RAM address (registered, holds when idle)
//   ram_wdata  RAM write data (registered, holds when idle)
//   ram_rdata  RAM read data, valid only the cycle after a read is issued

module spram_ctrl #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 64
) (
    input  logic           clk,
    input  logic           reset,
    spram_ctrl_if.slave    bus,
    output logic           ram_me,
    output logic           ram_wen,
    output logic [AW-1:0]  ram_addr,
    output logic [DW-1:0]  ram_wdata,
    input  logic [DW-1:0]  ram_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdCapt,
        StRsp
`ifdef SPRAM_CTRL_BYTE_EN
        ,
        StRmwRd,
        StRmwMrg,
        StRmwWr
`endif
    } state_e;

    state_e          state_q, state_d;
    logic            ram_me_q, ram_me_d;
    logic            ram_wen_q, ram_wen_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            idle_ready;
    logic            accept;

`ifdef SPRAM_CTRL_BYTE_EN
    localparam int unsigned BW = DW / 8;

    // Write data and enables held across the RMW sequence.
    logic [DW-1:0]   hold_wdata_q, hold_wdata_d;
    logic [BW-1:0]   hold_be_q, hold_be_d;
    logic [DW-1:0]   merged;

    always_comb begin
        merged = ram_rdata;
        for (int i = 0; i < int'(BW); i++) begin
            if (hold_be_q[i]) begin
                merged[8*i +: 8] = hold_wdata_q[8*i +: 8];
            end
        end
    end
`else
    logic unused_be;
    assign unused_be = ^bus.req_be;
`endif

    // Ready is gated by reset directly so nothing is accepted on a reset edge.
    assign idle_ready    = (state_q == StIdle) & ~reset;
    assign accept        = bus.req_valid & idle_ready;

    assign bus.req_ready = idle_ready;
    assign bus.rsp_valid = (state_q == StRsp);
    assign bus.rsp_rdata = rsp_rdata_q;

    assign ram_me        = ram_me_q;
    assign ram_wen       = ram_wen_q;
    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;

    always_comb begin
        state_d     = state_q;
        ram_me_d    = 1'b0;
        ram_wen_d   = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef SPRAM_CTRL_BYTE_EN
        hold_wdata_d = hold_wdata_q;
        hold_be_d    = hold_be_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bus.req_we) begin
`ifdef SPRAM_CTRL_BYTE_EN
                        if (&bus.req_be) begin
                            ram_me_d    = 1'b1;
                            ram_wen_d   = 1'b1;
                            ram_addr_d  = bus.req_addr;
                            ram_wdata_d = bus.req_wdata;
                        end else if (|bus.req_be) begin
                            // Partial write: fetch the old word first.
                            ram_me_d     = 1'b1;
                            ram_addr_d   = bus.req_addr;
                            hold_wdata_d = bus.req_wdata;
                            hold_be_d    = bus.req_be;
                            state_d      = StRmwRd;
                        end
`else
                        ram_me_d    = 1'b1;
                        ram_wen_d   = 1'b1;
                        ram_addr_d  = bus.req_addr;
                        ram_wdata_d = bus.req_wdata;
`endif
                    end else begin
                        ram_me_d   = 1'b1;
                        ram_addr_d = bus.req_addr;
                        state_d    = StRdIssue;
                    end
                end
            end
            // RAM read is on the pins this cycle.
            StRdIssue: state_d = StRdCapt;
            StRdCapt: begin
                rsp_rdata_d = ram_rdata;
                state_d     = StRsp;
            end
            StRsp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
`ifdef SPRAM_CTRL_BYTE_EN
            StRmwRd: state_d = StRmwMrg;
            StRmwMrg: begin
                ram_me_d    = 1'b1;
                ram_wen_d   = 1'b1;
                ram_wdata_d = merged;
                state_d     = StRmwWr;
            end
            StRmwWr: state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ram_me_q    <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rsp_rdata_q <= '0;
`ifdef SPRAM_CTRL_BYTE_EN
            hold_wdata_q <= '0;
            hold_be_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ram_me_q    <= ram_me_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef SPRAM_CTRL_BYTE_EN
            hold_wdata_q <= hold_wdata_d;
            hold_be_q    <= hold_be_d;
`endif
        end
    end

endmodule

// File: doc/spram_ctrl.md
# spram_ctrl

Request sequencer that sits directly upstream of the single-port 64-bit RAM, driving its `me`/`wen`/`addr`/`wdata` pins and capturing `rdata`. Converts a valid/ready request stream into correctly timed RAM cycles. Returns read data on a held valid/ready response channel. Optionally performs byte-masked writes by read-modify-write.

## Interface
- `AW`, 16, address width (RAM depth 2**AW words)
- `DW`, 64, data width; must be a multiple of 8
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller accepts request this cycle
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  AW  word address
- `req_wdata`  in  DW  write data
- `req_be`  in  DW/8  byte enables; bit i covers bits 8i+7:8i
- `rsp_valid`  out  1  read response present
- `rsp_ready`  in  1  consumer takes response
- `rsp_rdata`  out  DW  read data, stable while `rsp_valid`=1
- `ram_me`  out  1  RAM enable
- `ram_wen`  out  1  RAM write enable
- `ram_addr`  out  AW  RAM address
- `ram_wdata`  out  DW  RAM write data
- `ram_rdata`  in  DW  RAM read data; valid only in the cycle after a read is issued, undefined otherwise

## Operation
- Request is accepted on the edge where `req_valid & req_ready`. `req_ready` = 1 only in IDLE and never while `reset`=1.
- Writes produce no response.
- All `ram_*` outputs are registered. Each accepted access drives `ram_me`=1 for exactly one cycle per RAM operation.
- In cycles with no RAM operation, `ram_me`=0 and `ram_wen`=0. `ram_addr`/`ram_wdata` hold their last value.
- FSM states and transitions:
  - IDLE: write accepted -> stay IDLE (issue write); read accepted -> RD_ISSUE.
  - RD_ISSUE: `ram_me`=1, `ram_wen`=0 -> RD_CAPT.
  - RD_CAPT: sample `ram_rdata` into `rsp_rdata` -> RSP.
  - RSP: `rsp_valid`=1 until `rsp_valid & rsp_ready` -> IDLE.
  - RMW_RD -> RMW_MRG -> RMW_WR -> IDLE: only when `SPRAM_CTRL_BYTE_EN` is defined.
- Only one read is outstanding at a time; no request is accepted from read acceptance through the response handshake.
- `rsp_rdata` holds its value after the handshake until the next capture.
- Reset values: `req_ready`=0 (during reset), `rsp_valid`=0, `rsp_rdata`=0, `ram_me`=0, `ram_wen`=0, `ram_addr`=0, `ram_wdata`=0, state = IDLE.
- Reset mid-operation: any in-flight read or RMW is abandoned and its response discarded. `ram_me` is 0 in the cycle after the reset edge. A partially completed RMW never writes.
- Addresses wrap naturally at AW bits; no range check.

## Timing
- Write accepted at edge k: `ram_me`=`ram_wen`=1 with the address and data during cycle k+1, and the RAM commits at edge k+1.
- Back-to-back writes sustain one per cycle, with `ram_me` held high across consecutive cycles.
- Read accepted at edge k:
  - RAM read during cycle k+1.
  - `ram_rdata` sampled at edge k+2.
  - `rsp_valid`=1 from cycle k+3.
  - Minimum read latency is 3 cycles.
- If `rsp_ready`=1 in cycle k+3, the handshake occurs at edge k+3 and `req_ready`=1 in cycle k+4.
- `rsp_ready` held low stalls the response indefinitely, with `rsp_valid` and `rsp_rdata` stable.
- A write followed immediately by a read of the same address returns the new data, because the RAM operations are strictly ordered.

## Configuration
- `SPRAM_CTRL_BYTE_EN` defined: `req_be` is honoured on writes.
  - `be` all ones: plain single-cycle write.
  - `be`=0: accepted but no RAM access.
  - Partial `be`: write accepted at edge k runs the RMW sequence:
    - RMW_RD: RAM read, cycle k+1.
    - RMW_MRG: at edge k+2, enabled bytes are taken from `req_wdata` and the rest from `ram_rdata`.
    - RMW_WR: merged write, cycle k+3.
    - `req_ready`=1 in cycle k+4.
- Not defined: `req_be` is ignored, all writes are full-word, and RMW states do not exist.

## Test plan
- Reset then idle: hold `reset` 2 cycles -> all outputs 0 during reset; `req_ready`=1 in first cycle after release; `ram_me`=0.
- Write then read: write 0xDEADBEEF_CAFEF00D to 0x0010, then read 0x0010 -> `ram_me`/`ram_wen` pulse 1 cycle; `rsp_valid` 3 cycles after read accept with that data.
- Burst writes: 4 consecutive writes to 0x0000–0x0003 -> `ram_me`=1 for 4 consecutive cycles, `req_ready` never drops.
- Response backpressure: read 0xFFFF with `rsp_ready`=0 for 5 cycles -> `rsp_valid`/`rsp_rdata` stable, `req_ready`=0 throughout; released the cycle after the handshake.
- Reset mid-read: assert `reset` in the RD_CAPT cycle -> no `rsp_valid` ever; next read works normally.
- With `SPRAM_CTRL_BYTE_EN`: 0x0020 = 0x11223344_55667788, then write 0xAAAAAAAA_AAAAAAAA with `be`=0x0F -> RMW takes 4 cycles; read returns 0x11223344_AAAAAAAA; `be`=0x00 write produces no `ram_me`.
